// File: rtl/input_event_conditioner.sv
// Four-button front end: 2-flop synchroniser, debounce, per-button auto-repeat FSM,
// sticky pending register with overrun counter, exposed to the processor as a status word.
module input_event_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         DAS_DELAY       = 8000000,
    parameter int         DAS_REPEAT      = 2500000,
    parameter logic [3:0] REPEAT_MASK     = 4'b0111
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IO_left,
    input  logic        IO_right,
    input  logic        IO_down,
    input  logic        IO_rotate_cw,
    output logic [3:0]  held,
    output logic [3:0]  pulse,
    input  logic        evt_ack,
    input  logic [3:0]  evt_ack_mask,
    output logic [31:0] evt_word
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RC_MAX  = (DAS_DELAY > DAS_REPEAT) ? DAS_DELAY : DAS_REPEAT;
    localparam int RC_W    = $clog2(RC_MAX + 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || DAS_DELAY < 1 || DAS_REPEAT < 1) begin : g_param_check
            $error("input_event_conditioner: DEBOUNCE_CYCLES, DAS_DELAY and DAS_REPEAT must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;

    logic [3:0]      raw_n;
    logic [3:0]      sync_p0;
    logic [3:0]      sync_p1;
    logic [3:0]      stable;
    logic [3:0]      stable_d;
    logic [DB_W-1:0] db_cnt [4];
    logic [RC_W-1:0] rcnt   [4];
    rep_state_t      state  [4];
    logic [3:0]      pending;
    logic [7:0]      overrun;

    logic [3:0]      ack_clr;
    logic [3:0]      pending_nxt;
    logic [2:0]      ovr_inc;
    logic            ovr_clear;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    assign raw_n = {IO_rotate_cw, IO_down, IO_right, IO_left};
    assign held  = stable;

    // Stage p0/p1: synchroniser. Flops hold pressed polarity so a reset value reads as released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0  <= '0;
            sync_p1  <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0  <= ~raw_n;
            sync_p1  <= sync_p0;
            stable_d <= stable;
            for (int i = 0; i < 4; i++) begin
                if (sync_p1[i] != stable[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        stable[i] <= ~stable[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Auto-repeat FSMs: one press pulse, then DELAY -> REPEAT pulses while held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pulse <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                rcnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                pulse[i] <= 1'b0;
                if (!stable[i]) begin
                    state[i] <= IDLE;
                    rcnt[i]  <= '0;
                end else begin
                    case (state[i])
                        IDLE: begin
                            if (!stable_d[i]) begin
                                pulse[i] <= 1'b1;
                                if (REPEAT_MASK[i]) begin
                                    state[i] <= DELAY;
                                    rcnt[i]  <= '0;
                                end
                            end
                        end
                        DELAY: begin
                            if (rcnt[i] == RC_W'(DAS_DELAY - 1)) begin
                                pulse[i] <= 1'b1;
                                state[i] <= REPEAT;
                                rcnt[i]  <= '0;
                            end else begin
                                rcnt[i] <= rcnt[i] + RC_W'(1);
                            end
                        end
                        REPEAT: begin
                            if (rcnt[i] == RC_W'(DAS_REPEAT - 1)) begin
                                pulse[i] <= 1'b1;
                                rcnt[i]  <= '0;
                            end else begin
                                rcnt[i] <= rcnt[i] + RC_W'(1);
                            end
                        end
                        default: begin
                            state[i] <= IDLE;
                            rcnt[i]  <= '0;
                        end
                    endcase
                end
            end
        end
    end

    always_comb begin
        ack_clr     = evt_ack ? evt_ack_mask : 4'h0;
        pending_nxt = (pending & ~ack_clr) | pulse;
        ovr_inc     = 3'($countones(pulse & pending));
        ovr_clear   = evt_ack && (evt_ack_mask == 4'hF) && (pending == 4'h0);
    end

    // Event register stage; evt_word is sampled from the state before this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            overrun  <= '0;
            evt_word <= '0;
        end else begin
            pending  <= pending_nxt;
            overrun  <= ovr_clear ? 8'h00 : sat_add8(overrun, ovr_inc);
            evt_word <= {16'h0000, overrun, stable, pending};
        end
    end

endmodule

// File: tb/tb_input_event_conditioner.sv
// Directed bench for input_event_conditioner with small timing parameters; expected
// pulse edges are queued when a button is driven and matched by a per-cycle monitor.
module tb_input_event_conditioner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        IO_left = 1'b1;
    logic        IO_right = 1'b1;
    logic        IO_down = 1'b1;
    logic        IO_rotate_cw = 1'b1;
    logic [3:0]  held;
    logic [3:0]  pulse;
    logic        evt_ack = 1'b0;
    logic [3:0]  evt_ack_mask = 4'h0;
    logic [31:0] evt_word;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t;
    int r;

    typedef struct {
        int         edge_n;
        logic [3:0] val;
    } exp_t;
    exp_t exp_q[$];

    input_event_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .DAS_DELAY(10),
        .DAS_REPEAT(3),
        .REPEAT_MASK(4'b0111)
    ) dut (
        .clock(clock),
        .reset(reset),
        .IO_left(IO_left),
        .IO_right(IO_right),
        .IO_down(IO_down),
        .IO_rotate_cw(IO_rotate_cw),
        .held(held),
        .pulse(pulse),
        .evt_ack(evt_ack),
        .evt_ack_mask(evt_ack_mask),
        .evt_word(evt_word)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pulse(input int e, input logic [3:0] v);
        exp_q.push_back('{e, v});
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic ack(input logic [3:0] m);
        evt_ack      = 1'b1;
        evt_ack_mask = m;
        wait_edge(cyc + 1);
        evt_ack      = 1'b0;
        evt_ack_mask = 4'h0;
    endtask

    // Per-cycle pulse scoreboard: every cycle must match the queued expectation (or 0).
    always @(posedge clock) begin
        logic [3:0] exp_pulse;
        cyc = cyc + 1;
        #1;
        exp_pulse = 4'h0;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].edge_n == cyc) begin
                exp_pulse = exp_pulse | exp_q[i].val;
                exp_q.delete(i);
            end
        end
        check($sformatf("pulse@%0d", cyc), {28'h0, pulse}, {28'h0, exp_pulse});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_edge(3);
        check("rst_held", {28'h0, held}, 32'h0);
        check("rst_word", evt_word, 32'h0);
        reset = 1'b0;
        wait_edge(5);

        // 1: single press on left, released before the first auto-repeat
        t = cyc;
        IO_left = 1'b0;
        push_pulse(t + 7, 4'b0001);
        wait_edge(t + 5);
        check("t1_held_e5", {28'h0, held}, 32'h0);
        wait_edge(t + 6);
        check("t1_held_e6", {28'h0, held}, 32'h1);
        wait_edge(t + 8);
        IO_left = 1'b1;
        wait_edge(t + 9);
        check("t1_word_pend", evt_word, 32'h0000_0011);
        wait_edge(t + 20);
        check("t1_word_rel", evt_word, 32'h0000_0001);
        ack(4'b0001);
        wait_edge(cyc + 1);
        check("t1_word_ack", evt_word, 32'h0);

        // 2: glitch shorter than the debounce window
        t = cyc;
        IO_right = 1'b0;
        wait_edge(t + 3);
        IO_right = 1'b1;
        wait_edge(t + 5);
        check("t2_held", {28'h0, held}, 32'h0);
        wait_edge(t + 12);
        check("t2_word", evt_word, 32'h0);

        // 3: down held 30 cycles, auto-repeat
        t = cyc;
        IO_down = 1'b0;
        push_pulse(t + 7, 4'b0100);
        for (int k = 17; k <= 35; k += 3) push_pulse(t + k, 4'b0100);
        wait_edge(t + 30);
        IO_down = 1'b1;
        wait_edge(t + 35);
        check("t3_held_on", {28'h0, held}, 32'h4);
        wait_edge(t + 36);
        check("t3_held_off", {28'h0, held}, 32'h0);
        wait_edge(t + 40);
        check("t3_word_ovr", evt_word, 32'h0000_0704);
        ack(4'hF);
        wait_edge(cyc + 1);
        check("t3_ovr_kept", evt_word, 32'h0000_0700);
        ack(4'hF);
        wait_edge(cyc + 1);
        check("t3_ovr_clr", evt_word, 32'h0);

        // 4: rotate_cw has no auto-repeat
        t = cyc;
        IO_rotate_cw = 1'b0;
        push_pulse(t + 7, 4'b1000);
        wait_edge(t + 30);
        IO_rotate_cw = 1'b1;
        wait_edge(t + 40);
        check("t4_word_pend", evt_word, 32'h0000_0008);
        ack(4'b1000);
        check("t4_word_latency", evt_word, 32'h0000_0008);
        wait_edge(cyc + 1);
        check("t4_word_ack", evt_word, 32'h0);

        // 5: repeat pulse collides with acknowledge of the same bit
        t = cyc;
        IO_left = 1'b0;
        push_pulse(t + 7, 4'b0001);
        push_pulse(t + 17, 4'b0001);
        wait_edge(t + 12);
        IO_left = 1'b1;
        wait_edge(t + 17);
        evt_ack = 1'b1;
        evt_ack_mask = 4'b0001;
        wait_edge(t + 18);
        evt_ack = 1'b0;
        evt_ack_mask = 4'h0;
        wait_edge(t + 19);
        check("t5_set_wins", evt_word, 32'h0000_0101);
        ack(4'b0001);
        ack(4'hF);
        wait_edge(cyc + 1);
        check("t5_word_clr", evt_word, 32'h0);

        // 6: reset while down is in REPEAT and still held
        t = cyc;
        IO_down = 1'b0;
        push_pulse(t + 7, 4'b0100);
        push_pulse(t + 17, 4'b0100);
        push_pulse(t + 20, 4'b0100);
        wait_edge(t + 21);
        reset = 1'b1;
        #1;
        check("t6_rst_held", {28'h0, held}, 32'h0);
        check("t6_rst_pulse", {28'h0, pulse}, 32'h0);
        check("t6_rst_word", evt_word, 32'h0);
        wait_edge(t + 24);
        r = cyc;
        reset = 1'b0;
        push_pulse(r + 7, 4'b0100);
        push_pulse(r + 17, 4'b0100);
        wait_edge(r + 5);
        check("t6_held_e5", {28'h0, held}, 32'h0);
        wait_edge(r + 6);
        check("t6_held_e6", {28'h0, held}, 32'h4);
        wait_edge(r + 12);
        IO_down = 1'b1;
        wait_edge(r + 25);
        check("t6_word", evt_word, 32'h0000_0104);

        wait_edge(cyc + 3);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
